// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two writeback ports, load-issue
// and flush controls, and scoreboard status.
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2
);
    logic [NRD*AW-1:0]   i_rs_addr;
    logic [NRD*XLEN-1:0] o_rs_data;
    logic [NRD-1:0]      o_rs_busy;
    logic                i_wa_en;
    logic [AW-1:0]       i_wa_addr;
    logic [XLEN-1:0]     i_wa_data;
    logic                i_wb_en;
    logic [AW-1:0]       i_wb_addr;
    logic [XLEN-1:0]     i_wb_data;
    logic                i_issue_en;
    logic [AW-1:0]       i_issue_addr;
    logic                i_flush;
    logic                o_any_busy;

    modport master (
        output i_rs_addr, i_wa_en, i_wa_addr, i_wa_data,
        output i_wb_en, i_wb_addr, i_wb_data, i_issue_en, i_issue_addr, i_flush,
        input  o_rs_data, o_rs_busy, o_any_busy
    );

    modport slave (
        input  i_rs_addr, i_wa_en, i_wa_addr, i_wa_data,
        input  i_wb_en, i_wb_addr, i_wb_data, i_issue_en, i_issue_addr, i_flush,
        output o_rs_data, o_rs_busy, o_any_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file: two writeback ports with read bypass,
// hardwired-zero r0, and a per-register outstanding-load busy scoreboard.
module regfile_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    regfile_mp_if.slave bus
);
    logic [XLEN-1:0]     r_regs [1:NREGS-1];
    logic [NREGS-1:1]    r_busy;
    logic                r_any_busy;

    logic [NREGS-1:1]    w_busy_next;
    logic [XLEN-1:0]     w_regs [NREGS];
    logic [NREGS-1:0]    w_busy;
    logic [AW-1:0]       w_rd_addr [NRD];
    logic [NRD*XLEN-1:0] w_rs_data;
    logic [NRD-1:0]      w_rs_busy;

    // NOTE: the storage array is reset too, because reset must read back as
    // zero immediately; that is why it is built from plain flops, not a RAM.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 1; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (bus.i_wb_en && bus.i_wb_addr == AW'(i))
                    r_regs[i] <= bus.i_wb_data;
                else if (bus.i_wa_en && bus.i_wa_addr == AW'(i))
                    r_regs[i] <= bus.i_wa_data;
            end
        end
    end

    // Flush beats issue; issue beats a same-cycle load return.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_busy_next = r_busy;
        for (int i = 1; i < NREGS; i++) begin
            if (bus.i_flush)
                w_busy_next[i] = 1'b0;
            else if (bus.i_issue_en && bus.i_issue_addr == AW'(i))
                w_busy_next[i] = 1'b1;
            else if (bus.i_wb_en && bus.i_wb_addr == AW'(i))
                w_busy_next[i] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_any_busy <= 1'b0;
        end else begin
            r_busy     <= w_busy_next;
            r_any_busy <= |w_busy_next;
        end
    end

    always_comb begin
        w_regs[0] = '0;
        for (int i = 1; i < NREGS; i++) w_regs[i] = r_regs[i];
        w_busy = {r_busy, 1'b0};
    end

    // Reads return the value the register will hold after this edge.
    always_comb begin
        w_rs_data = '0;
        w_rs_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            w_rd_addr[k] = bus.i_rs_addr[k*AW +: AW];
            if (i_rst || w_rd_addr[k] == '0)
                w_rs_data[k*XLEN +: XLEN] = '0;
            else if (bus.i_wb_en && bus.i_wb_addr == w_rd_addr[k])
                w_rs_data[k*XLEN +: XLEN] = bus.i_wb_data;
            else if (bus.i_wa_en && bus.i_wa_addr == w_rd_addr[k])
                w_rs_data[k*XLEN +: XLEN] = bus.i_wa_data;
            else
                w_rs_data[k*XLEN +: XLEN] = w_regs[w_rd_addr[k]];
            w_rs_busy[k] = w_busy[w_rd_addr[k]]
                         && !(bus.i_wb_en && bus.i_wb_addr == w_rd_addr[k])
                         && (w_rd_addr[k] != '0);
        end
    end

    assign bus.o_rs_data  = w_rs_data;
    assign bus.o_rs_busy  = w_rs_busy;
    assign bus.o_any_busy = r_any_busy;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the core's single-write, two-read register file.
- Configurable data width, register count and number of read ports.
- Two write ports: A = ALU/execute writeback, B = load/long-latency writeback.
- Write-to-read bypass on both write ports.
- Per-register busy scoreboard: set at load issue, cleared at load writeback, so decode can stall on RAW hazards against outstanding loads.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers including hardwired-zero register 0; power of two, at least 2.
- AW, $clog2(NREGS), register address width.
- NRD, 2, number of read ports, at least 1.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rs_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- o_rs_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- o_rs_busy  out  NRD  port k source register has an outstanding load.
- i_wa_en  in  1  write port A enable.
- i_wa_addr  in  AW  write port A address.
- i_wa_data  in  XLEN  write port A data.
- i_wb_en  in  1  write port B enable; also clears the busy bit.
- i_wb_addr  in  AW  write port B address.
- i_wb_data  in  XLEN  write port B data.
- i_issue_en  in  1  a load targeting i_issue_addr was issued; sets busy.
- i_issue_addr  in  AW  load destination.
- i_flush  in  1  synchronous clear of all busy bits (pipeline flush).
- o_any_busy  out  1  OR of all busy bits.

Behaviour:
- Storage:
  - Registers 1..NREGS-1 are XLEN-bit flops; register 0 has no storage.
  - Reads of address 0 return 0; writes to address 0 are ignored.
  - The busy bit for register 0 is never set.
- Reset:
  - i_rst high clears every register and every busy bit immediately, without waiting for a clock edge.
  - While i_rst is high: o_rs_data = 0, o_rs_busy = 0, o_any_busy = 0, and all writes, issues and flushes are ignored.
  - The first update happens on the first rising edge after i_rst deasserts.
- Write:
  - On the rising edge, an enabled port with a nonzero address writes its data.
  - If A and B target the same nonzero address in the same cycle, B wins.
- Read (combinational, zero latency), evaluated in this priority order:
  - Address 0 -> 0.
  - Else i_wb_en with matching address -> i_wb_data.
  - Else i_wa_en with matching address -> i_wa_data.
  - Else the stored value.
- Read ports are independent; any ports may share an address.
- Scoreboard next-state per register r ≠ 0, evaluated in this priority order:
  - i_flush -> 0. Flush overrides an issue in the same cycle.
  - Else i_issue_en with issue address r -> 1. A new issue overrides a same-cycle clear, because the new load is still outstanding.
  - Else i_wb_en with B address r -> 0.
  - Else hold.
- Port A writes do not affect busy bits.
- Busy output:
  - o_rs_busy[k] = busy[addr_k] AND NOT (i_wb_en AND i_wb_addr == addr_k) AND addr_k ≠ 0.
  - A load returning this cycle is bypassed, so it reports not-busy.
  - A same-cycle issue is not visible until the next cycle (registered).
- o_any_busy:
  - Registered OR of the busy bits.
  - No bypass; reflects the state after the last edge.
- No handshake or backpressure; every enabled write and issue is accepted every cycle.

Test Plan:
1. Reset mid-operation:
   - Write A to r5 = 0xDEADBEEF, issue load to r7, then pulse i_rst high between clock edges.
   - Required: o_rs_data reads 0 for r5 and o_any_busy = 0 before the next edge.
2. Zero register:
   - Port A writes 0x12345678 to r0; port B writes to r0; issue to r0.
   - Required: reads of r0 return 0 on all NRD ports, bypass included; o_rs_busy = 0; o_any_busy stays 0.
3. Dual-write conflict:
   - Same cycle: A writes r3 = 0x1111, B writes r3 = 0x2222.
   - Required: same-cycle read of r3 = 0x2222; next cycle r3 = 0x2222.
   - Separately, A writes r4 = 0xAAAA while B writes r6 = 0xBBBB: both stored.
4. Scoreboard lifecycle:
   - Issue r9 at cycle t: o_rs_busy = 0 at t, 1 at t+1..t+4.
   - B writes r9 = 0x55 at t+5: same-cycle read of r9 gives busy = 0, data 0x55; busy bit 0 from t+6.
5. Issue/clear collision and flush:
   - r2 busy; in one cycle B writes r2 and a new issue targets r2.
   - Required: r2 busy next cycle, data updated.
   - Then i_flush together with an issue to r8: all busy bits 0 next cycle, o_any_busy = 0.
6. Parametrisation:
   - Configure NRD = 3, NREGS = 16, XLEN = 64.
   - Write r15 = 0xFFFF_0000_1234_5678; all three ports read r15 simultaneously and return that value.
   - Write to address 15 does not alias any other register.
